// File: rtl/c_realign_pkg.sv
// c_realign_pkg: shared types, constants and helpers for the RVC realign buffer
package c_realign_pkg;
  typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RUN} state_t;
  localparam logic [31:0] NOP = 32'h0000_0013;
  function automatic logic is_compressed(input logic [15:0] hw);
    return hw[1:0] != 2'b11;
  endfunction
endpackage

// File: rtl/c_hw_queue.sv
// c_hw_queue: halfword circular queue, pushes 0..NHW and pops 0..2 halfwords per cycle
module c_hw_queue #(
  parameter int NHW = 2,
  parameter int DEPTH_HW = 4,
  localparam int PW = $clog2(DEPTH_HW),
  localparam int CW = $clog2(DEPTH_HW + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [CW-1:0]     push_cnt,
  input  logic [NHW*16-1:0] push_data,
  input  logic [1:0]        pop_cnt,
  output logic [15:0]       h0,
  output logic [15:0]       h1,
  output logic [CW-1:0]     count
);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH_HW);
  logic [15:0] mem [DEPTH_HW];
  logic [PW-1:0] rd_ptr, wr_ptr;
  assign h0 = mem[rd_ptr];
  assign h1 = mem[rd_ptr + PW'(1)];
  // storage writes: the first push_cnt halfwords land at consecutive slots from wr_ptr
  always_ff @(posedge clk) begin
    for (int i = 0; i < NHW; i++)
      if (CW'(i) < push_cnt) mem[wr_ptr + PW'(i)] <= push_data[i*16 +: 16];
  end
  // pointer and occupancy bookkeeping; clear empties the queue
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      wr_ptr <= wr_ptr + PW'(push_cnt);
      count  <= count + push_cnt - CW'(pop_cnt);
    end
  end
  a_no_overflow:  assert property (@(posedge clk) disable iff (reset) count <= DEPTH_C);
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) CW'(pop_cnt) <= count);
endmodule

// File: rtl/c_realign_buffer.sv
// c_realign_buffer: carves aligned 16/32-bit instructions from fetch words (C_REALIGN_PERF_EN adds perf counters)
module c_realign_buffer
  import c_realign_pkg::*;
#(
  parameter int FETCH_W = 32,
  parameter int DEPTH_HW = 4,
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush_i,
  input  logic [XLEN-1:0]    flush_pc_i,
  input  logic               fetch_valid_i,
  input  logic [FETCH_W-1:0] fetch_data_i,
  output logic               fetch_ready_o,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [31:0]        inst_o,
  output logic [XLEN-1:0]    inst_pc_o,
  output logic               inst_is_c_o
`ifdef C_REALIGN_PERF_EN
  ,
  output logic [31:0]        perf_c_cnt_o,
  output logic [31:0]        perf_starve_cnt_o
`endif
);
  localparam int NHW = FETCH_W / 16;
  localparam int CW = $clog2(DEPTH_HW + 1);
  localparam int OW = $clog2(FETCH_W / 8) - 1;
  localparam logic [CW-1:0] NHW_C = CW'(NHW);
  localparam logic [CW-1:0] ROOM_C = CW'(DEPTH_HW - NHW);
  state_t state, state_n;
  logic [OW-1:0] off;
  logic [XLEN-1:0] head_pc;
  logic [15:0] h0, h1;
  logic [CW-1:0] count, push_cnt;
  logic [1:0] pop_cnt;
  logic comp, push, pop;
  assign comp          = is_compressed(h0);
  assign fetch_ready_o = (state != S_IDLE) && (count <= ROOM_C);
  assign push          = fetch_valid_i && fetch_ready_o && !flush_i;
  assign inst_valid_o  = !flush_i && (comp ? count != '0 : count > CW'(1));
  assign pop           = inst_valid_o && inst_ready_i;
  assign inst_o        = !inst_valid_o ? 32'h0 : comp ? {16'h0, h0} : {h1, h0};
  assign inst_is_c_o   = inst_valid_o && comp;
  assign inst_pc_o     = head_pc;
  assign push_cnt      = !push ? '0 : state == S_ALIGN ? NHW_C - CW'(off) : NHW_C;
  assign pop_cnt       = !pop ? 2'd0 : comp ? 2'd1 : 2'd2;
  c_hw_queue #(.NHW(NHW), .DEPTH_HW(DEPTH_HW)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush_i),
    .push_cnt  (push_cnt),
    .push_data (state == S_ALIGN ? fetch_data_i >> {off, 4'b0} : fetch_data_i),
    .pop_cnt   (pop_cnt),
    .h0        (h0),
    .h1        (h1),
    .count     (count)
  );
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? S_IDLE : state_n;
  end
  // next state: any flush realigns, the first accepted word starts streaming
  always_comb begin
    state_n = state;
    state_n = flush_i ? S_ALIGN : (state == S_ALIGN && push) ? S_RUN : state;
  end
  // redirect offset and PC of the instruction at the queue head
  always_ff @(posedge clk) begin
    if (reset) begin
      off     <= '0;
      head_pc <= '0;
    end else if (flush_i) begin
      off     <= flush_pc_i[OW:1];
      head_pc <= flush_pc_i & ~XLEN'(1);
    end else if (pop) begin
      head_pc <= head_pc + (comp ? XLEN'(2) : XLEN'(4));
    end
  end
`ifdef C_REALIGN_PERF_EN
  // saturating event counters, untouched by flush
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_c_cnt_o      <= '0;
      perf_starve_cnt_o <= '0;
    end else begin
      if (pop && comp && perf_c_cnt_o != '1) perf_c_cnt_o <= perf_c_cnt_o + 32'd1;
      if (state == S_RUN && !inst_valid_o && perf_starve_cnt_o != '1) perf_starve_cnt_o <= perf_starve_cnt_o + 32'd1;
    end
  end
`endif
endmodule
